// File: rtl/seq_banda_if.sv
// Bus bundle between seq_banda and its sample source / MAC / reg_banda bank.
// With SEQ_BANDA_MASCARA_EN defined the bundle also carries the band mask.
interface seq_banda_if #(
    parameter int N_BANDAS = 3,
    parameter int SEL_W    = 2
);
    logic                muestra_lista;
    logic                clr_desborde;
    logic [SEL_W-1:0]    sel_banda;
    logic                mac_clr;
    logic                mac_en;
    logic [N_BANDAS-1:0] leer;
    logic [N_BANDAS-1:0] escribir;
    logic                ocupado;
    logic                listo;
    logic                desborde;
`ifdef SEQ_BANDA_MASCARA_EN
    logic [N_BANDAS-1:0] mascara;

    modport master (
        output muestra_lista, clr_desborde, mascara,
        input  sel_banda, mac_clr, mac_en, leer, escribir, ocupado, listo, desborde
    );
    modport slave (
        input  muestra_lista, clr_desborde, mascara,
        output sel_banda, mac_clr, mac_en, leer, escribir, ocupado, listo, desborde
    );
`else
    modport master (
        output muestra_lista, clr_desborde,
        input  sel_banda, mac_clr, mac_en, leer, escribir, ocupado, listo, desborde
    );
    modport slave (
        input  muestra_lista, clr_desborde,
        output sel_banda, mac_clr, mac_en, leer, escribir, ocupado, listo, desborde
    );
`endif
endinterface

// File: rtl/seq_banda.sv
// Per-sample band sequencer: walks the bands through a shared MAC, captures each
// result, then publishes all bands at once. Optional band mask: SEQ_BANDA_MASCARA_EN.
module seq_banda #(
    parameter int N_BANDAS = 3,
    parameter int LAT_MAC  = 4,
    parameter int SEL_W    = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    seq_banda_if.slave   bus
);
    localparam int CNT_W = $clog2(LAT_MAC + 1);

    typedef enum logic [2:0] {REPOSO, LIMPIA, CALCULA, CAPTURA, PUBLICA} estado_t;

    estado_t             estado_q, estado_d;
    logic [SEL_W-1:0]    band_q, band_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_BANDAS-1:0] mask_ini, mask_act;
    logic                hay_pri, hay_sig;
    logic [SEL_W-1:0]    pri_band, sig_band;

`ifdef SEQ_BANDA_MASCARA_EN
    logic [N_BANDAS-1:0] mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mask_q <= '0;
        else if (estado_q == REPOSO && bus.muestra_lista)
            mask_q <= bus.mascara;
    end

    assign mask_ini = bus.mascara;
    assign mask_act = mask_q;
`else
    assign mask_ini = '1;
    assign mask_act = '1;
`endif

    // First enabled band at sequence start, and next enabled band above the current one.
    always_comb begin
        hay_pri  = 1'b0;
        pri_band = '0;
        hay_sig  = 1'b0;
        sig_band = band_q;
        for (int unsigned i = 0; i < N_BANDAS; i++) begin
            if (!hay_pri && mask_ini[i]) begin
                hay_pri  = 1'b1;
                pri_band = SEL_W'(i);
            end
            if (!hay_sig && i > 32'(band_q) && mask_act[i]) begin
                hay_sig  = 1'b1;
                sig_band = SEL_W'(i);
            end
        end
    end

    always_comb begin
        estado_d = estado_q;
        band_d   = band_q;
        cnt_d    = cnt_q;
        case (estado_q)
            REPOSO: begin
                band_d = '0;
                if (bus.muestra_lista) begin
                    if (hay_pri) begin
                        estado_d = LIMPIA;
                        band_d   = pri_band;
                    end else begin
                        estado_d = PUBLICA;
                    end
                end
            end
            LIMPIA: begin
                cnt_d    = CNT_W'(LAT_MAC);
                estado_d = CALCULA;
            end
            CALCULA: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    estado_d = CAPTURA;
            end
            CAPTURA: begin
                if (hay_sig) begin
                    band_d   = sig_band;
                    estado_d = LIMPIA;
                end else begin
                    estado_d = PUBLICA;
                end
            end
            PUBLICA: begin
                band_d   = '0;
                estado_d = REPOSO;
            end
            default: begin
                band_d   = '0;
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= REPOSO;
            band_q   <= '0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            band_q   <= band_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.sel_banda <= '0;
            bus.mac_clr   <= 1'b0;
            bus.mac_en    <= 1'b0;
            bus.leer      <= '0;
            bus.escribir  <= '0;
            bus.ocupado   <= 1'b0;
            bus.listo     <= 1'b0;
            bus.desborde  <= 1'b0;
        end else begin
            bus.sel_banda <= (estado_d != REPOSO) ? band_d : '0;
            bus.mac_clr   <= (estado_d == LIMPIA);
            bus.mac_en    <= (estado_d == CALCULA);
            bus.leer      <= (estado_d == CAPTURA) ? (N_BANDAS'(1) << band_d) : '0;
            bus.escribir  <= (estado_d == PUBLICA) ? '1 : '0;
            bus.ocupado   <= (estado_d != REPOSO);
            bus.listo     <= (estado_d == PUBLICA);
            if (bus.muestra_lista && estado_q != REPOSO)
                bus.desborde <= 1'b1;
            else if (bus.clr_desborde)
                bus.desborde <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_banda.sv
// Self-checking bench for seq_banda: directed vector tables, hand sequences for
// reset/mask corners, and random traffic against a cycle-offset reference model.
module tb_seq_banda;
    localparam int NB  = 3;
    localparam int LAT = 4;
    localparam int SW  = 2;
    localparam int PER = LAT + 2;

    typedef logic [12:0] outv_t;   // {mac_clr, mac_en, leer, escribir, listo, ocupado, desborde, sel}
    typedef struct {
        int    t;
        logic  ml;
        logic  clr;
        outv_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state: cycles since acceptance (0 = idle), bands to process
    int   mcyc = 0;
    int   mnb = 0;
    int   mbands[NB];
    logic mdesb = 1'b0;

    seq_banda_if #(.N_BANDAS(NB), .SEL_W(SW)) bus ();

    seq_banda #(.N_BANDAS(NB), .LAT_MAC(LAT), .SEL_W(SW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic outv_t ov(logic mc, logic me, logic [2:0] le, logic [2:0] es,
                                 logic li, logic oc, logic de, logic [1:0] sl);
        return {mc, me, le, es, li, oc, de, sl};
    endfunction

    function automatic outv_t pack_act();
        return {bus.mac_clr, bus.mac_en, bus.leer, bus.escribir, bus.listo,
                bus.ocupado, bus.desborde, bus.sel_banda};
    endfunction

    function automatic outv_t model_out();
        logic mc, me, li, oc;
        logic [2:0] le, es;
        logic [1:0] sl;
        int k, r;
        mc = 0; me = 0; li = 0; oc = 0; le = '0; es = '0; sl = '0;
        if (mcyc != 0) begin
            oc = 1;
            if (mcyc <= mnb * PER) begin
                k  = (mcyc - 1) / PER;
                r  = (mcyc - 1) % PER;
                sl = 2'(mbands[k]);
                if (r == 0)        mc = 1;
                else if (r <= LAT) me = 1;
                else               le = 3'(1 << mbands[k]);
            end else begin
                es = 3'b111;
                li = 1;
                sl = (mnb > 0) ? 2'(mbands[mnb-1]) : 2'd0;
            end
        end
        return {mc, me, le, es, li, oc, mdesb, sl};
    endfunction

    task automatic model_update(input logic ml, input logic clr, input logic [NB-1:0] msk);
        logic [NB-1:0] m;
        logic busy;
`ifdef SEQ_BANDA_MASCARA_EN
        m = msk;
`else
        m = '1;
`endif
        busy = (mcyc != 0);
        if (ml && busy) mdesb = 1'b1;
        else if (clr)   mdesb = 1'b0;
        if (busy) begin
            mcyc++;
            if (mcyc > mnb * PER + 1) mcyc = 0;
        end else if (ml) begin
            mnb = 0;
            for (int i = 0; i < NB; i++)
                if (m[i]) begin mbands[mnb] = i; mnb++; end
            mcyc = 1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives inputs for this cycle, advances one clock, checks model.
    task automatic tick(input logic ml, input logic clr, input logic [NB-1:0] msk);
        bus.muestra_lista = ml;
        bus.clr_desborde  = clr;
`ifdef SEQ_BANDA_MASCARA_EN
        bus.mascara = msk;
`endif
        @(posedge clk);
        if (!reset_n) begin mcyc = 0; mdesb = 1'b0; end
        else model_update(ml, clr, msk);
        @(negedge clk);
        chk("model", 32'(pack_act()), 32'(model_out()));
        bus.muestra_lista = 1'b0;
        bus.clr_desborde  = 1'b0;
    endtask

    task automatic run_table(input string nm, input vec_t tab[$]);
        int cyc;
        cyc = 0;
        foreach (tab[i]) begin
            while (cyc < tab[i].t) begin tick(1'b0, 1'b0, '1); cyc++; end
            chk($sformatf("%s_t%0d", nm, tab[i].t), 32'(pack_act()), 32'(tab[i].exp));
            tick(tab[i].ml, tab[i].clr, '1);
            cyc++;
        end
    endtask

    initial begin
        vec_t ta[$];
        vec_t tb[$];
        bus.muestra_lista = 1'b0;
        bus.clr_desborde  = 1'b0;
`ifdef SEQ_BANDA_MASCARA_EN
        bus.mascara = '1;
`endif
        // single sample with a mid-sequence overrun and a later clear
        ta = '{
            '{0,  1'b1, 1'b0, ov(0,0,3'b000,3'b000,0,0,0,2'd0)},
            '{1,  1'b0, 1'b0, ov(1,0,3'b000,3'b000,0,1,0,2'd0)},
            '{2,  1'b0, 1'b0, ov(0,1,3'b000,3'b000,0,1,0,2'd0)},
            '{6,  1'b0, 1'b0, ov(0,0,3'b001,3'b000,0,1,0,2'd0)},
            '{7,  1'b0, 1'b0, ov(1,0,3'b000,3'b000,0,1,0,2'd1)},
            '{10, 1'b1, 1'b0, ov(0,1,3'b000,3'b000,0,1,0,2'd1)},
            '{11, 1'b0, 1'b0, ov(0,1,3'b000,3'b000,0,1,1,2'd1)},
            '{12, 1'b0, 1'b0, ov(0,0,3'b010,3'b000,0,1,1,2'd1)},
            '{13, 1'b0, 1'b0, ov(1,0,3'b000,3'b000,0,1,1,2'd2)},
            '{18, 1'b0, 1'b0, ov(0,0,3'b100,3'b000,0,1,1,2'd2)},
            '{19, 1'b0, 1'b0, ov(0,0,3'b000,3'b111,1,1,1,2'd2)},
            '{20, 1'b0, 1'b0, ov(0,0,3'b000,3'b000,0,0,1,2'd0)},
            '{25, 1'b0, 1'b1, ov(0,0,3'b000,3'b000,0,0,1,2'd0)},
            '{26, 1'b0, 1'b0, ov(0,0,3'b000,3'b000,0,0,0,2'd0)}
        };
        // back-to-back samples, then a sample landing on the publish cycle
        tb = '{
            '{0,  1'b1, 1'b0, ov(0,0,3'b000,3'b000,0,0,0,2'd0)},
            '{19, 1'b0, 1'b0, ov(0,0,3'b000,3'b111,1,1,0,2'd2)},
            '{20, 1'b1, 1'b0, ov(0,0,3'b000,3'b000,0,0,0,2'd0)},
            '{21, 1'b0, 1'b0, ov(1,0,3'b000,3'b000,0,1,0,2'd0)},
            '{39, 1'b1, 1'b0, ov(0,0,3'b000,3'b111,1,1,0,2'd2)},
            '{40, 1'b0, 1'b0, ov(0,0,3'b000,3'b000,0,0,1,2'd0)}
        };

        // reset and idle
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(pack_act()), 32'(0));
        reset_n = 1'b1;
        repeat (10) tick(1'b0, 1'b0, '1);
        chk("idle_ocupado", 32'(bus.ocupado), 32'(0));

        run_table("seqA", ta);
        repeat (3) tick(1'b0, 1'b0, '1);
        tick(1'b0, 1'b1, '1);
        run_table("seqB", tb);
        tick(1'b0, 1'b1, '1);
        chk("desb_cleared", 32'(bus.desborde), 32'(0));

        // reset mid-sequence: strobes drop at once, no publish follows
        tick(1'b1, 1'b0, '1);
        for (int c = 1; c < 9; c++) tick(c == 3, 1'b0, '1);
        chk("pre_reset_desb", 32'(bus.desborde), 32'(1));
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 32'(pack_act()), 32'(0));
        mcyc = 0; mdesb = 1'b0;
        @(negedge clk);
        tick(1'b0, 1'b0, '1);
        reset_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick(1'b0, 1'b0, '1);
            chk("no_escribir_after_reset", 32'(bus.escribir), 32'(0));
        end
        tick(1'b1, 1'b0, '1);
        chk("restart_band0", 32'({bus.mac_clr, bus.sel_banda}), 32'({1'b1, 2'd0}));
        repeat (20) tick(1'b0, 1'b0, '1);

`ifdef SEQ_BANDA_MASCARA_EN
        // mask 101: bands 0 and 2 only
        tick(1'b1, 1'b0, 3'b101);
        for (int c = 1; c <= 13; c++) begin
            if (c == 6)  chk("mask101_leer_t6",  32'(bus.leer), 32'(3'b001));
            if (c == 12) chk("mask101_leer_t12", 32'(bus.leer), 32'(3'b100));
            if (c == 13) chk("mask101_escr_t13", 32'({bus.escribir, bus.listo}), 32'({3'b111, 1'b1}));
            tick(1'b0, 1'b0, 3'b000);
        end
        chk("mask101_done", 32'(bus.ocupado), 32'(0));
        tick(1'b1, 1'b0, 3'b000);
        chk("mask000_listo_t1", 32'({bus.listo, bus.escribir, bus.leer}), 32'({1'b1, 3'b111, 3'b000}));
        tick(1'b0, 1'b0, '1);
        chk("mask000_idle", 32'(bus.ocupado), 32'(0));
`endif

        // random traffic against the model
        for (int c = 0; c < 3000; c++)
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0, 3'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
